// File: rtl/decoder_pipe.sv
// Registered one-hot decoder with a two-entry skid buffer and valid/ready flow control.
// Optional macro DECODER_ZERO_REG_EN: an all-ones select stores an all-zero word.
module decoder_pipe #(
  parameter int SEL_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_enable,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic [1:0]              dbg_state
);

  localparam int OUT_W = 1 << SEL_W;

  // Handshake: a transfer happens on an edge where valid and ready are both high.
  // in_ready depends only on registered occupancy and flush, never on out_ready.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [OUT_W-1:0]   r_main;
  logic [OUT_W-1:0]   r_skid;
  logic [OUT_W-1:0]   w_word;
  logic               w_accept;
  logic               w_drain;

  assign w_accept = in_valid & in_ready;
  assign w_drain  = out_valid & out_ready;

  always_comb begin
    w_word         = '0;
    w_word[in_sel] = in_enable;
`ifdef DECODER_ZERO_REG_EN
    if (&in_sel) w_word = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_accept && !w_drain)      w_state_nxt = S_TWO;
          else if (!w_accept && w_drain) w_state_nxt = S_EMPTY;
        end
        S_TWO:   if (w_drain) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (r_state != S_EMPTY);
    in_ready  = (r_state != S_TWO) & ~flush;
    out       = out_valid ? r_main : '0;
    dbg_state = r_state;
  end

  // Main is cleared whenever it goes empty so out stays zero without relying on the mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (flush) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) r_main <= w_word;
        S_ONE: begin
          if (w_accept && w_drain) r_main <= w_word;
          else if (w_accept)       r_skid <= w_word;
          else if (w_drain)        r_main <= '0;
        end
        S_TWO: begin
          if (w_drain) begin
            r_main <= r_skid;
            r_skid <= '0;
          end
        end
        default: begin
          r_main <= '0;
          r_skid <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe: queue-based reference model checked every cycle plus directed literal checks.
module tb_decoder_pipe;

  localparam int SEL_W = 5;
  localparam int OUT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             in_enable;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out;
  logic [1:0]       dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  logic [OUT_W-1:0] exp_q[$];

  decoder_pipe #(.SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_enable (in_enable),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [OUT_W-1:0] model_word(input logic [SEL_W-1:0] sel, input logic en);
    logic [OUT_W-1:0] w;
    w = en ? (OUT_W'(1) << sel) : '0;
`ifdef DECODER_ZERO_REG_EN
    if (sel == SEL_W'(OUT_W - 1)) w = '0;
`endif
    return w;
  endfunction

  // reference model: a FIFO of at most two decoded words
  always @(negedge rst_n) exp_q.delete();

  always @(posedge clk) begin
    if (rst_n) begin
      bit acc, drn;
      acc = in_valid && (exp_q.size() < 2) && !flush;
      drn = (exp_q.size() > 0) && out_ready;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (drn) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(model_word(in_sel, in_enable));
      end
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      check("m_out", 64'(out), (exp_q.size() > 0) ? 64'(exp_q[0]) : 64'd0);
      check("m_in_ready", 64'(in_ready), 64'((exp_q.size() < 2) && !flush));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic e);
    in_valid  = v;
    in_sel    = s;
    in_enable = e;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, 1'b0);
    repeat (2) tick();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out", 64'(out), 64'd0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // single transfer
    out_ready = 1'b1;
    drive(1'b1, 5'd5, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    check("single_out", 64'(out), 64'h0000_0020);
    check("single_valid", 64'(out_valid), 64'd1);
    tick();
    check("single_drained", 64'(out_valid), 64'd0);

    // enable low
    drive(1'b1, 5'd12, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    check("enlow_valid", 64'(out_valid), 64'd1);
    check("enlow_out", 64'(out), 64'd0);
    tick();

    // backpressure
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 1'b1);
    tick();
    drive(1'b1, 5'd2, 1'b1);
    tick();
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_full_out", 64'(out), 64'h2);
    drive(1'b1, 5'd3, 1'b1);
    tick();
    check("bp_stall_ready", 64'(in_ready), 64'd0);
    check("bp_stall_out", 64'(out), 64'h2);
    out_ready = 1'b1;
    tick();
    check("bp_drain1_out", 64'(out), 64'h4);
    check("bp_drain1_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, '0, 1'b0);
    check("bp_drain2_out", 64'(out), 64'h8);
    tick();
    check("bp_empty", 64'(out_valid), 64'd0);

    // flush while full
    out_ready = 1'b0;
    drive(1'b1, 5'd7, 1'b1);
    tick();
    drive(1'b1, 5'd8, 1'b1);
    tick();
    flush = 1'b1;
    drive(1'b1, 5'd9, 1'b1);
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out", 64'(out), 64'd0);
    tick();
    check("flush_nothing_taken", 64'(out_valid), 64'd0);

    // asynchronous reset with two entries held
    drive(1'b1, 5'd4, 1'b1);
    tick();
    drive(1'b1, 5'd6, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_out", 64'(out), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("async_rst_ready", 64'(in_ready), 64'd1);

    // all-ones select
    out_ready = 1'b1;
    drive(1'b1, 5'd31, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    check("zero_reg_valid", 64'(out_valid), 64'd1);
`ifdef DECODER_ZERO_REG_EN
    check("zero_reg_out", 64'(out), 64'd0);
`else
    check("zero_reg_out", 64'(out), 64'h8000_0000);
`endif
    tick();

    // mixed traffic, checked by the model only
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 3) != 0), SEL_W'($urandom_range(0, OUT_W - 1)),
            1'($urandom_range(0, 4) != 0));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 30) == 0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    check("final_empty", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
# decoder_pipe

Parametrised, registered one-hot decoder with valid/ready flow control, used as the write-port select stage between writeback and the register file. Each accepted transaction carries a select and an enable and is decoded into a `2**SEL_W`-bit one-hot word, with a two-entry skid buffer so that both handshakes run at full rate. The block replaces the fixed-width, purely combinational decoders wherever a decoded select crosses a pipeline boundary.

## Interface
- `SEL_W`, default 5: select width. Output width `OUT_W = 2**SEL_W` is a derived localparam. Legal range is 1..6.

- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous, active-low reset
- `flush`  input  1  synchronous discard of all buffered entries
- `in_valid`  input  1  producer has a transaction
- `in_ready`  output  1  block can accept a transaction this cycle
- `in_sel`  input  SEL_W  port select
- `in_enable`  input  1  value driven onto the selected bit (0 gives an all-zero word)
- `out_valid`  output  1  `out` holds a valid decoded word
- `out_ready`  input  1  consumer accepts `out` this cycle
- `out`  output  OUT_W  one-hot (or zero) decoded word

## Operation
- Decoding happens at acceptance: the stored word is `in_enable << in_sel`. Only decoded words are stored; selects are not stored.
- Storage is a main register (drives `out`) and one skid register.
- Occupancy state machine:
  - EMPTY: `out_valid=0`, `in_ready=1`.
  - ONE: main register valid, `in_ready=1`.
  - TWO: both registers valid, `in_ready=0`.
- Definitions: accept = `in_valid & in_ready`; drain = `out_valid & out_ready`.
- Transitions:
  - EMPTY → ONE on accept.
  - ONE → EMPTY on drain without accept.
  - ONE → TWO on accept without drain.
  - ONE stays ONE on accept and drain together; main is reloaded with the new word.
  - TWO → ONE on drain; skid moves into main.
- Ordering is strict FIFO. No transaction is dropped or duplicated except by `flush` or reset.
- `in_ready = (state != TWO) & ~flush`. It depends only on registered state and `flush`, never on `out_ready`.
- `flush`:
  - Next state is EMPTY and both registers clear to 0.
  - Any input in a flush cycle is not accepted (`in_ready` is low).
  - A drain in the flush cycle still counts as delivered.
- `out` is 0 whenever `out_valid=0`.

## Timing
- Reset (asynchronous, `rst_n` low):
  - State is EMPTY, `out_valid=0`, `out=0`, both registers are 0, and `in_ready=1` after deassertion.
- Reset mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency: accepted at edge N, the word is visible on `out` with `out_valid=1` after edge N.
- Throughput: one transaction per cycle while `out_ready=1`.
- Backpressure: with `out_ready` held low, two transactions are absorbed and `in_ready` falls after the second acceptance edge.
- After `out_ready` rises:
  - The first drain edge moves skid into main and `in_ready` returns to 1.
  - Entries are then delivered on consecutive cycles.
- `flush` takes effect at the next edge. `out_valid=0` in the following cycle.
- Out-of-range select cannot occur, since `in_sel` width equals `SEL_W`.

## Configuration
- Macro `DECODER_ZERO_REG_EN`:
  - Defined: a select of all ones (X31/XZR when `SEL_W=5`) stores an all-zero word regardless of `in_enable`. The transaction still handshakes and produces `out_valid=1`.
  - Undefined: all ones decodes normally (`out[OUT_W-1]=in_enable`).

## Test plan
- Reset: assert `rst_n=0` mid-stream with TWO entries.
  - Required: `out_valid=0`, `out=0` immediately; `in_ready=1` after release.
- Single transfer, `SEL_W=5`, `out_ready=1`: `in_sel=5`, `in_enable=1` at edge N.
  - Required: `out=32'h0000_0020`, `out_valid=1` after N; `out_valid=0` after N+1 with no new input.
- Enable low: `in_sel=12`, `in_enable=0`.
  - Required: `out_valid=1`, `out=0`.
- Backpressure: `out_ready=0`, offer selects 1, 2, 3 back-to-back.
  - Required: 1 and 2 accepted, `in_ready=0` while 3 stalls.
  - Then raise `out_ready`: outputs `0x2`, `0x4`, `0x8` on consecutive cycles.
- Flush: in TWO, assert `flush` for one cycle together with `in_valid`.
  - Required: the input is not accepted and `out_valid=0` next cycle.
- Macro: with `DECODER_ZERO_REG_EN`, `in_sel=31`, `in_enable=1` gives `out=0`, `out_valid=1`.
  - Without the macro: `out=32'h8000_0000`.
